regfile_wb: RTL and testbench

Write-back register file for the single-cycle CPU: 2^AW general registers of DW bits with one synchronous write port and two asynchronous read ports. It sits between the write-back select path and the ALU operand path. The write side decodes the destination address into a one-hot register enable and applies byte lanes; the read sides return register contents to the datapath. Register 0 is hardwired to zero.

---
 rtl/regfile_wb.sv | 111 +++++++++++
 tb/tb_regfile_wb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
// regfile_wb: write-back register file for the single-cycle CPU.
// 2^AW registers of DW bits. Writes are synchronous with byte-lane enables.
// Two combinational read ports with optional same-cycle write forwarding.
// Register 0 always reads as zero and is never written.
module regfile_wb #(
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic [DW-1:0]       wdata,
   input  logic [DW/8-1:0]     wbe,
   input  logic [AW-1:0]       ra1,
   input  logic [AW-1:0]       ra2,
   output logic [DW-1:0]       rd1,
   output logic [DW-1:0]       rd2,
   output logic [(2**AW)-1:0]  wsel,
   output logic [15:0]         wcnt
);

   localparam int NREG = 2**AW;
   localparam int NB   = DW/8;

   logic [DW-1:0]   regs [NREG];
   logic [DW-1:0]   laneMask;
   logic [NREG-1:0] wenOnehot;
   logic [NREG-1:0] commitVec;
   logic            commit;
   logic            bypassHit1;
   logic            bypassHit2;
   logic [DW-1:0]   merged1;
   logic [DW-1:0]   merged2;

   // Expand the byte enables into a bit mask covering each 8-bit lane
   always_comb begin
      laneMask = '0;
      for (int i = 0; i < NB; i++) begin
         laneMask[8*i +: 8] = {8{wbe[i]}};
      end
   end

   // One-hot destination decode; register 0 can never be selected
   always_comb begin
      wenOnehot = '0;
      for (int k = 1; k < NREG; k++) begin
         wenOnehot[k] = we && (waddr == AW'(k));
      end
   end

   // A write only counts as committed if at least one lane is enabled
   always_comb begin
      commitVec = wenOnehot & {NREG{|wbe}};
      commit    = |commitVec;
   end

   // Register storage: reset clears everything, otherwise merge enabled lanes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NREG; k++) begin
            regs[k] <= '0;
         end
      end else begin
         for (int k = 1; k < NREG; k++) begin
            if (wenOnehot[k]) begin
               regs[k] <= (regs[k] & ~laneMask) | (wdata & laneMask);
            end
         end
      end
   end

   // Last-commit one-hot and wrapping commit counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wsel <= '0;
         wcnt <= '0;
      end else begin
         wsel <= commitVec;
         if (commit) begin
            wcnt <= wcnt + 16'd1;
         end
      end
   end

   // Forwarding detection and merged value for both read ports
   always_comb begin
      bypassHit1 = (BYPASS != 0) && rst_n && we && (waddr == ra1);
      bypassHit2 = (BYPASS != 0) && rst_n && we && (waddr == ra2);
      merged1    = (regs[ra1] & ~laneMask) | (wdata & laneMask);
      merged2    = (regs[ra2] & ~laneMask) | (wdata & laneMask);
   end

   // Read port 1: zero register, forwarded write, or stored value
   always_comb begin
      rd1 = '0;
      if (ra1 != '0) begin
         rd1 = bypassHit1 ? merged1 : regs[ra1];
      end
   end

   // Read port 2: same selection as port 1, fully independent
   always_comb begin
      rd2 = '0;
      if (ra2 != '0) begin
         rd2 = bypassHit2 ? merged2 : regs[ra2];
      end
   end

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: scoreboard bench for regfile_wb.
// Drives one forwarding instance and one non-forwarding instance with the
// same inputs; expected responses come from an array-based model and are
// queued for a monitor that compares on the falling edge.
module tb_regfile_wb;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [3:0]  wbe;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] rd1B, rd2B, rd1N, rd2N;
   logic [31:0] wselB, wselN;
   logic [15:0] wcntB, wcntN;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] rd1B;
      logic [31:0] rd2B;
      logic [31:0] rd1N;
      logic [31:0] rd2N;
      logic [31:0] wsel;
      logic [15:0] wcnt;
   } exp_t;

   exp_t expQ[$];

   // Reference model state
   logic [31:0] mRegs [32];
   logic [31:0] mWsel;
   logic [15:0] mWcnt;

   regfile_wb #(.DW(32), .AW(5), .BYPASS(1)) dutB (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .wbe(wbe), .ra1(ra1), .ra2(ra2), .rd1(rd1B), .rd2(rd2B),
      .wsel(wselB), .wcnt(wcntB)
   );

   regfile_wb #(.DW(32), .AW(5), .BYPASS(0)) dutN (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .wbe(wbe), .ra1(ra1), .ra2(ra2), .rd1(rd1N), .rd2(rd2N),
      .wsel(wselN), .wcnt(wcntN)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-wise merge of new data into an old word
   function automatic logic [31:0] mergeBytes(input logic [31:0] oldV,
                                              input logic [31:0] newV,
                                              input logic [3:0] be);
      logic [31:0] r;
      r = oldV;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = newV[8*i +: 8];
      end
      return r;
   endfunction

   // What a read port should show this cycle
   function automatic logic [31:0] modelRead(input logic [4:0] ra, input bit fwd);
      if (ra == 5'd0) return 32'h0;
      if (fwd && rst_n && we && waddr == ra) return mergeBytes(mRegs[ra], wdata, wbe);
      return mRegs[ra];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] expV);
      checks++;
      if (act !== expV) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expV);
      end
   endtask

   // Drive one cycle, optionally queue its expectation, then advance the model
   task automatic applyStimulus(input string name, input logic rstV, input logic weV,
                                input logic [4:0] waV, input logic [31:0] wdV,
                                input logic [3:0] beV, input logic [4:0] r1,
                                input logic [4:0] r2, input bit chk);
      exp_t e;
      bit   isCommit;
      rst_n = rstV; we = weV; waddr = waV; wdata = wdV; wbe = beV;
      ra1 = r1; ra2 = r2;
      if (chk) begin
         e.name = name;
         e.rd1B = modelRead(r1, 1'b1);
         e.rd2B = modelRead(r2, 1'b1);
         e.rd1N = modelRead(r1, 1'b0);
         e.rd2N = modelRead(r2, 1'b0);
         e.wsel = mWsel;
         e.wcnt = mWcnt;
         expQ.push_back(e);
      end
      @(posedge clk);
      if (!rstV) begin
         for (int k = 0; k < 32; k++) mRegs[k] = 32'h0;
         mWsel = 32'h0;
         mWcnt = 16'h0;
      end else begin
         isCommit = weV && (waV != 5'd0) && (beV != 4'd0);
         mWsel = isCommit ? (32'h1 << waV) : 32'h0;
         if (isCommit) begin
            mRegs[waV] = mergeBytes(mRegs[waV], wdV, beV);
            mWcnt = mWcnt + 16'd1;
         end
      end
      #1;
   endtask

   // Monitor: compare every queued expectation in the middle of its cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.name, ".rd1_fwd"}, rd1B, e.rd1B);
            checkOutput({e.name, ".rd2_fwd"}, rd2B, e.rd2B);
            checkOutput({e.name, ".rd1_nofwd"}, rd1N, e.rd1N);
            checkOutput({e.name, ".rd2_nofwd"}, rd2N, e.rd2N);
            checkOutput({e.name, ".wsel_fwd"}, wselB, e.wsel);
            checkOutput({e.name, ".wsel_nofwd"}, wselN, e.wsel);
            checkOutput({e.name, ".wcnt_fwd"}, {16'h0, wcntB}, {16'h0, e.wcnt});
            checkOutput({e.name, ".wcnt_nofwd"}, {16'h0, wcntN}, {16'h0, e.wcnt});
         end
      end
   end

   // Global time limit so the run always ends
   initial begin
      #5000000;
      $display("[TB] FAIL timeout: simulation did not complete, got running, expected done");
      $fatal(1, "[TB] timeout");
   end

   // Main stimulus sequence
   initial begin
      logic [4:0]  a, r1, r2;
      logic [3:0]  be;
      logic        w, rs;
      for (int k = 0; k < 32; k++) mRegs[k] = 32'h0;
      mWsel = 32'h0;
      mWcnt = 16'h0;
      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wbe = '0; ra1 = '0; ra2 = '0;
      #1;

      // Reset, then sweep both read ports over every register
      applyStimulus("reset0", 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b0);
      applyStimulus("reset1", 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd1, 5'd2, 1'b1);
      for (int i = 0; i < 32; i++) begin
         applyStimulus("sweep", 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(31 - i), 1'b1);
      end

      // Full-word write then read back
      applyStimulus("fullwr", 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd0, 5'd0, 1'b1);
      applyStimulus("fullrd", 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5, 1'b1);

      // Byte-lane partial write
      applyStimulus("lane_init", 1'b1, 1'b1, 5'd7, 32'h11223344, 4'hF, 5'd0, 5'd0, 1'b1);
      applyStimulus("lane_wr", 1'b1, 1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 5'd7, 5'd1, 1'b1);
      applyStimulus("lane_rd", 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd5, 1'b1);

      // Writes to register 0 and writes with no lanes enabled
      applyStimulus("zero_wr", 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd3, 1'b1);
      applyStimulus("nolane_wr", 1'b1, 1'b1, 5'd3, 32'hFFFFFFFF, 4'h0, 5'd0, 5'd3, 1'b1);
      applyStimulus("zero_rd", 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd3, 1'b1);

      // Forwarding against stored value
      applyStimulus("byp_init", 1'b1, 1'b1, 5'd9, 32'h12345678, 4'hF, 5'd0, 5'd0, 1'b1);
      applyStimulus("byp_wr", 1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 4'hC, 5'd9, 5'd9, 1'b1);
      applyStimulus("byp_rd", 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd9, 1'b1);

      // Reset beats a simultaneous write; forwarding suppressed in reset
      applyStimulus("rst_wr", 1'b0, 1'b1, 5'd4, 32'h55AA55AA, 4'hF, 5'd4, 5'd9, 1'b1);
      applyStimulus("rst_rd", 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd4, 5'd9, 1'b1);

      // Randomized traffic with occasional reset and frequent forwarding hits
      for (int n = 0; n < 1500; n++) begin
         a  = 5'($urandom_range(0, 31));
         be = 4'($urandom);
         w  = 1'($urandom);
         rs = ($urandom_range(0, 49) != 0);
         r1 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom);
         r2 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom);
         applyStimulus("rand", rs, w, a, $urandom, be, r1, r2, 1'b1);
      end

      // Counter wrap: clear, then drive 65535 commits, then two more
      applyStimulus("wrap_rst", 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b1);
      for (int n = 0; n < 65535; n++) begin
         applyStimulus("wrap_bulk", 1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom,
                       4'($urandom_range(1, 15)), 5'($urandom), 5'($urandom),
                       (n % 4096) == 0);
      end
      applyStimulus("wrap_ffff", 1'b1, 1'b1, 5'd12, 32'h0BADF00D, 4'hF, 5'd12, 5'd1, 1'b1);
      applyStimulus("wrap_zero", 1'b1, 1'b1, 5'd13, 32'h600DCAFE, 4'h3, 5'd12, 5'd13, 1'b1);
      applyStimulus("wrap_one", 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd12, 5'd13, 1'b1);

      // Let the monitor drain the queue within a bounded number of cycles
      for (int t = 0; t < 10 && expQ.size() > 0; t++) @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
